// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_pkg
// Description : Shared types and helpers for the line-FIFO burst drain
//               scheduler: FSM state encoding, burst length width, skid depth.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

  // Scheduler states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Default full-burst length in beats
  localparam int BURST_LEN_DEFAULT = 16;

  // Width of the burst_len port (covers 1..256)
  localparam int BURST_LEN_W = 9;

  // Skid buffer depth: two entries cover the 1-cycle FIFO read latency
  localparam int SKID_DEPTH = 2;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Bits needed to hold a skid entry count of 0..SKID_DEPTH
  localparam int SKID_CNT_W = clog2(SKID_DEPTH + 1);

endpackage : fifo_ctrl_pkg
`default_nettype wire

// File: rtl/fifo_ctrl_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_skid
// Description : 2-entry valid/ready skid buffer fed by a FIFO with 1-cycle
//               read latency. Entry count is exported so the scheduler can
//               keep reads in flight without ever overrunning the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl_skid
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SKID_CNT_W-1:0] count
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [SKID_CNT_W-1:0] count_q, count_d;
  logic                  pop;

  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign count     = count_q;
  assign pop       = out_valid && pop_ready;

  // Next-state of the two entries: head is always the oldest beat
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_valid, pop})
      2'b10: begin
        if (count_q == '0) head_d = push_data;
        else               tail_d = push_data;
        count_d = count_q + SKID_CNT_W'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - SKID_CNT_W'(1);
      end
      2'b11: begin
        if (count_q == SKID_CNT_W'(1)) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Entry storage; cleared on reset so wdata reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule : fifo_ctrl_skid
`default_nettype wire

// File: rtl/fifo_burst_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_drain_ctrl
// Description : Read-side scheduler for the sync line FIFO. Tracks occupancy,
//               drains in BURST_LEN bursts via burst_req/burst_ack and a
//               per-beat valid/ready handshake, and flushes the remainder as
//               a short burst on frame_end.
//               Optional overflow counter: define FIFO_CTRL_ERR_CNT_EN to add
//               err_cnt / err_ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_drain_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = BURST_LEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_wr_en,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   frame_end,
  output logic                   burst_req,
  output logic [BURST_LEN_W-1:0] burst_len,
  input  logic                   burst_ack,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic                   wvalid,
  input  logic                   wready,
  output logic                   wlast,
  output logic [ADDR_WIDTH:0]    level,
  output logic                   busy,
`ifdef FIFO_CTRL_ERR_CNT_EN
  output logic [15:0]            err_cnt,
  output logic                   err_ovf,
`endif
  output logic                   flush_done
);

  localparam int LVL_W = ADDR_WIDTH + 1;

  state_t                 state_q, state_d;
  logic [BURST_LEN_W-1:0] len_q, len_d;
  logic [BURST_LEN_W-1:0] fetched_q, fetched_d;
  logic [BURST_LEN_W-1:0] sent_q, sent_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   pending_q, pending_d;
  logic                   inflight_q;
  logic                   flush_clear;
  logic                   wr_accept;
  logic                   beat_fire;
  logic                   is_last;
  logic [SKID_CNT_W-1:0]  skid_count;
  logic [2:0]             slots_used;

  fifo_ctrl_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_valid (inflight_q),
    .push_data  (fifo_rd_data),
    .pop_ready  (wready),
    .out_valid  (wvalid),
    .out_data   (wdata),
    .count      (skid_count)
  );

  assign wr_accept = fifo_wr_en && !fifo_full;
  assign beat_fire = wvalid && wready;
  assign is_last   = (sent_q == len_q - BURST_LEN_W'(1));
  assign wlast     = wvalid && is_last;
  assign burst_len = len_q;
  assign level     = level_q;
  assign busy      = (state_q != IDLE);

  // Skid slots that stay occupied after this cycle's pop, counting the read
  // already in flight; keeping this below 2 sustains 1 beat/cycle safely.
  assign slots_used = 3'(skid_count) + 3'(inflight_q) - 3'(beat_fire);

  // Scheduler next-state and outputs
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    fetched_d   = fetched_q;
    sent_d      = sent_q;
    burst_req   = 1'b0;
    fifo_rd_en  = 1'b0;
    flush_done  = 1'b0;
    flush_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q >= LVL_W'(BURST_LEN)) begin
          state_d = REQ;
          len_d   = BURST_LEN_W'(BURST_LEN);
        end else if (pending_q && (level_q != '0)) begin
          state_d = REQ;
          len_d   = BURST_LEN_W'(level_q);
        end else if (pending_q) begin
          flush_done  = 1'b1;
          flush_clear = 1'b1;
        end
      end
      REQ: begin
        burst_req = 1'b1;
        if (burst_ack) begin
          state_d   = DATA;
          fetched_d = '0;
          sent_d    = '0;
        end
      end
      DATA: begin
        if ((slots_used < 3'd2) && (fetched_q < len_q) && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          fetched_d  = fetched_q + BURST_LEN_W'(1);
        end
        if (beat_fire) begin
          sent_d = sent_q + BURST_LEN_W'(1);
          if (is_last) begin
            state_d = IDLE;
            if (pending_q && (level_q == '0)) begin
              flush_done  = 1'b1;
              flush_clear = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy and sticky flush request
  always_comb begin
    level_d = level_q + LVL_W'(wr_accept) - LVL_W'(fifo_rd_en);
    if (flush_clear) pending_d = 1'b0;
    else             pending_d = pending_q | frame_end;
  end

  // Scheduler registers; reset aborts any burst in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      fetched_q  <= '0;
      sent_q     <= '0;
      level_q    <= '0;
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      fetched_q  <= fetched_d;
      sent_q     <= sent_d;
      level_q    <= level_d;
      pending_q  <= pending_d;
      inflight_q <= fifo_rd_en;
    end
  end

`ifdef FIFO_CTRL_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_ovf_q, err_ovf_d;
  logic        ovf_attempt;

  assign ovf_attempt = fifo_wr_en && fifo_full;
  assign err_cnt     = err_cnt_q;
  assign err_ovf     = err_ovf_q;

  // Saturating overflow-attempt counter and sticky flag
  always_comb begin
    err_cnt_d = err_cnt_q;
    err_ovf_d = err_ovf_q | ovf_attempt;
    if (ovf_attempt && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Overflow statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_ovf_q <= err_ovf_d;
    end
  end
`endif

endmodule : fifo_burst_drain_ctrl
`default_nettype wire
